// File: rtl/dot_product_acc_if.sv
// dot_product_acc_if
// Groups the three element streams of the dot-product accumulator:
//   Input_1_V_V / _ap_vld / _ap_ack   vector A element stream (32-bit signed)
//   Input_2_V_V / _ap_vld / _ap_ack   vector B element stream (32-bit signed)
//   Output_1_V_V / _ap_vld / _ap_ack  dot-product result stream
// Modports:
//   master - leaf-interface side: produces A/B elements, accepts results
//   slave  - accelerator side: consumes A/B elements, produces results
interface dot_product_acc_if;
  logic [31:0] Input_1_V_V;
  logic        Input_1_V_V_ap_vld;
  logic        Input_1_V_V_ap_ack;
  logic [31:0] Input_2_V_V;
  logic        Input_2_V_V_ap_vld;
  logic        Input_2_V_V_ap_ack;
  logic [31:0] Output_1_V_V;
  logic        Output_1_V_V_ap_vld;
  logic        Output_1_V_V_ap_ack;

  modport master (
    output Input_1_V_V, Input_1_V_V_ap_vld,
    input  Input_1_V_V_ap_ack,
    output Input_2_V_V, Input_2_V_V_ap_vld,
    input  Input_2_V_V_ap_ack,
    input  Output_1_V_V, Output_1_V_V_ap_vld,
    output Output_1_V_V_ap_ack
  );

  modport slave (
    input  Input_1_V_V, Input_1_V_V_ap_vld,
    output Input_1_V_V_ap_ack,
    input  Input_2_V_V, Input_2_V_V_ap_vld,
    output Input_2_V_V_ap_ack,
    output Output_1_V_V, Output_1_V_V_ap_vld,
    input  Output_1_V_V_ap_ack
  );
endinterface

// File: rtl/dot_product_acc.sv
// dot_product_acc
// Streaming dot-product accumulator. Joins one A and one B element per cycle
// (both consumed together), accumulates the low 32 bits of their signed
// product, and after VEC_LEN joins presents the wrapped sum on the result
// stream, holding it until accepted.
// Parameters:
//   VEC_LEN   element pairs per dot product (1..65535)
//   CNT_BITS  width of the element counter
// Ports:
//   ap_clk    clock
//   ap_rst_n  asynchronous active-low reset
//   ap_start  level enable, sampled on leaving IDLE and on result hand-off
//   ap_idle   high while in IDLE
//   ap_done   one-cycle pulse the cycle after a result is accepted
//   ap_ready  identical to ap_done
//   bus       element/result streams (slave side)
module dot_product_acc #(
  parameter int VEC_LEN  = 64,
  parameter int CNT_BITS = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_ready,
  dot_product_acc_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [31:0]         acc;
  logic [31:0]         result;
  logic [31:0]         prod;
  logic [31:0]         sum;
  logic [CNT_BITS-1:0] cnt;
  logic                join_fire;
  logic                last_elem;
  logic                out_fire;
  logic                done_q;

  // The low 32 bits of a two's-complement product do not depend on operand
  // signedness, so a plain 32x32 multiply truncated to 32 bits is exact here.
  always_comb begin
    join_fire = (state == ACC) && bus.Input_1_V_V_ap_vld && bus.Input_2_V_V_ap_vld;
    prod      = bus.Input_1_V_V * bus.Input_2_V_V;
    sum       = acc + prod;
    last_elem = (cnt == CNT_BITS'(VEC_LEN - 1));
    out_fire  = (state == OUT) && bus.Output_1_V_V_ap_ack;
  end

  // ap_start only matters when leaving IDLE or when the result is handed off;
  // dropping it mid-vector does not abort accumulation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ap_start) state_next = ACC;
      ACC:  if (join_fire && last_elem) state_next = OUT;
      OUT:  if (out_fire) state_next = ap_start ? ACC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // On the final join the completed sum goes straight into the result
  // register and the accumulator restarts from zero for the next vector.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_fire;
      if (join_fire) begin
        if (last_elem) begin
          result <= sum;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.Input_1_V_V_ap_ack  = join_fire;
    bus.Input_2_V_V_ap_ack  = join_fire;
    bus.Output_1_V_V        = result;
    bus.Output_1_V_V_ap_vld = (state == OUT);
    ap_idle                 = (state == IDLE);
    ap_done                 = done_q;
    ap_ready                = done_q;
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc
// Drives three accumulator instances (VEC_LEN 4, 2 and 1) and compares their
// results against a plain-arithmetic dot-product model.
module tb_dot_product_acc;

  typedef int ivec_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start4, start2, start1;
  logic idle4, done4, ready4;
  logic idle2, done2, ready2;
  logic idle1, done1, ready1;

  dot_product_acc_if bus4();
  dot_product_acc_if bus2();
  dot_product_acc_if bus1();

  dot_product_acc #(.VEC_LEN(4), .CNT_BITS(16)) u4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start4),
    .ap_idle(idle4), .ap_done(done4), .ap_ready(ready4), .bus(bus4.slave));

  dot_product_acc #(.VEC_LEN(2), .CNT_BITS(16)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start2),
    .ap_idle(idle2), .ap_done(done2), .ap_ready(ready2), .bus(bus2.slave));

  dot_product_acc #(.VEC_LEN(1), .CNT_BITS(16)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start1),
    .ap_idle(idle1), .ap_done(done1), .ap_ready(ready1), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] got4[$];
  int done4_cnt = 0;

  // Reference: sum of exact signed products, reduced mod 2^32.
  function automatic logic [31:0] dot_model(input ivec_t a, input ivec_t b);
    longint s = 0;
    for (int i = 0; i < a.size(); i++) s += longint'(a[i]) * longint'(b[i]);
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol watcher on the VEC_LEN=4 instance: acks paired and only with both
  // valids, no input ack while a result waits, pending result stays stable.
  logic        prev_pending = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      checks++;
      if (bus4.Input_1_V_V_ap_ack !== bus4.Input_2_V_V_ap_ack ||
          (bus4.Input_1_V_V_ap_ack === 1'b1 &&
           !(bus4.Input_1_V_V_ap_vld && bus4.Input_2_V_V_ap_vld)) ||
          (bus4.Output_1_V_V_ap_vld === 1'b1 && bus4.Input_1_V_V_ap_ack !== 1'b0)) begin
        errors++;
        $display("[TB] FAIL ack_protocol: ackA=%b ackB=%b vldA=%b vldB=%b outvld=%b required paired acks only on join",
                 bus4.Input_1_V_V_ap_ack, bus4.Input_2_V_V_ap_ack, bus4.Input_1_V_V_ap_vld,
                 bus4.Input_2_V_V_ap_vld, bus4.Output_1_V_V_ap_vld);
      end
      if (prev_pending) begin
        checks++;
        if (bus4.Output_1_V_V_ap_vld !== 1'b1 || bus4.Output_1_V_V !== prev_data) begin
          errors++;
          $display("[TB] FAIL out_stable: vld=%b data=%h required vld=1 data=%h",
                   bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V, prev_data);
        end
      end
      if (bus4.Output_1_V_V_ap_vld === 1'b1 && bus4.Output_1_V_V_ap_ack === 1'b1)
        got4.push_back(bus4.Output_1_V_V);
      if (done4 === 1'b1) done4_cnt++;
      prev_pending = (bus4.Output_1_V_V_ap_vld === 1'b1) && (bus4.Output_1_V_V_ap_ack !== 1'b1);
      prev_data    = bus4.Output_1_V_V;
    end
  end

  // Presents the vector element by element on bus4 until each one is joined.
  task automatic run_vec4(input ivec_t a, input ivec_t b, input int vld_pct, input int ack_pct);
    int j = 0;
    int guard = 0;
    while (j < a.size() && guard < 300) begin
      bus4.Input_1_V_V = a[j];
      bus4.Input_2_V_V = b[j];
      bus4.Input_1_V_V_ap_vld = (int'($urandom_range(99)) < vld_pct);
      bus4.Input_2_V_V_ap_vld = (int'($urandom_range(99)) < vld_pct);
      if (ack_pct >= 0) bus4.Output_1_V_V_ap_ack = (int'($urandom_range(99)) < ack_pct);
      @(negedge clk);
      if (bus4.Input_1_V_V_ap_ack === 1'b1) j++;
      tick();
      guard++;
    end
    bus4.Input_1_V_V_ap_vld = 1'b0;
    bus4.Input_2_V_V_ap_vld = 1'b0;
    checks++;
    if (j != a.size()) begin
      errors++;
      $display("[TB] FAIL join_timeout: joined %0d required %0d", j, a.size());
    end
  endtask

  task automatic wait_result4(input logic [31:0] expv, input string name);
    int guard = 0;
    logic [31:0] r;
    bus4.Output_1_V_V_ap_ack = 1'b1;
    while (got4.size() == 0 && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (got4.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no result, required %h", name, expv);
    end else begin
      r = got4.pop_front();
      if (r !== expv) begin
        errors++;
        $display("[TB] FAIL %s: got %h required %h", name, r, expv);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 1'b1; start2 = 1'b0; start1 = 1'b0;
    bus4.Input_1_V_V = 32'd3; bus4.Input_2_V_V = 32'd4;
    bus4.Input_1_V_V_ap_vld = 1'b1; bus4.Input_2_V_V_ap_vld = 1'b1;
    bus4.Output_1_V_V_ap_ack = 1'b0;
    bus2.Input_1_V_V = '0; bus2.Input_2_V_V = '0;
    bus2.Input_1_V_V_ap_vld = 1'b0; bus2.Input_2_V_V_ap_vld = 1'b0;
    bus2.Output_1_V_V_ap_ack = 1'b0;
    bus1.Input_1_V_V = '0; bus1.Input_2_V_V = '0;
    bus1.Input_1_V_V_ap_vld = 1'b0; bus1.Input_2_V_V_ap_vld = 1'b0;
    bus1.Output_1_V_V_ap_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (idle4 !== 1'b1 || idle2 !== 1'b1 || idle1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: idle4=%b idle2=%b idle1=%b required 1", idle4, idle2, idle1);
    end
    checks++;
    if (bus4.Input_1_V_V_ap_ack !== 1'b0 || bus4.Input_2_V_V_ap_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ack: ackA=%b ackB=%b required 0", bus4.Input_1_V_V_ap_ack, bus4.Input_2_V_V_ap_ack);
    end
    checks++;
    if (bus4.Output_1_V_V_ap_vld !== 1'b0 || bus4.Output_1_V_V !== 32'd0 || done4 !== 1'b0 || ready4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out: vld=%b data=%h done=%b ready=%b required all 0",
               bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V, done4, ready4);
    end
    bus4.Input_1_V_V_ap_vld = 1'b0; bus4.Input_2_V_V_ap_vld = 1'b0;
    start4 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (idle4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_hold: idle4=%b required 1 with start low", idle4);
    end
    tick();
  endtask

  task automatic test_basic();
    int av[4] = '{1, 2, 3, 4};
    int bv[4] = '{5, 6, 7, 8};
    ivec_t qa, qb;
    int j = 0;
    int guard = 0;
    logic [31:0] expv;
    foreach (av[i]) begin qa.push_back(av[i]); qb.push_back(bv[i]); end
    expv = dot_model(qa, qb);
    got4.delete();
    start4 = 1'b1;
    bus4.Output_1_V_V_ap_ack = 1'b1;
    while (j < 4 && guard < 20) begin
      bus4.Input_1_V_V = av[j]; bus4.Input_2_V_V = bv[j];
      bus4.Input_1_V_V_ap_vld = 1'b1; bus4.Input_2_V_V_ap_vld = 1'b1;
      @(negedge clk);
      if (bus4.Input_1_V_V_ap_ack === 1'b1) j++;
      tick();
      guard++;
    end
    bus4.Input_1_V_V_ap_vld = 1'b0; bus4.Input_2_V_V_ap_vld = 1'b0;
    checks++;
    if (j != 4) begin
      errors++;
      $display("[TB] FAIL basic_joins: joined %0d required 4", j);
    end
    @(negedge clk);
    checks++;
    if (bus4.Output_1_V_V_ap_vld !== 1'b1 || bus4.Output_1_V_V !== expv || done4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: vld=%b data=%h done=%b required vld=1 data=%h done=0",
               bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V, done4, expv);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done4 !== 1'b1 || ready4 !== 1'b1 || bus4.Output_1_V_V_ap_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done: done=%b ready=%b vld=%b required 1 1 0", done4, ready4, bus4.Output_1_V_V_ap_vld);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || got4.size() != 1) begin
      errors++;
      $display("[TB] FAIL basic_single: done=%b results=%0d required done=0 results=1", done4, got4.size());
    end
    tick();
    got4.delete();
  endtask

  task automatic test_backpressure();
    int av[4] = '{3, -5, 7, 11};
    int bv[4] = '{2, 4, -6, 8};
    ivec_t qa, qb, na, nb;
    logic [31:0] expv;
    foreach (av[i]) begin qa.push_back(av[i]); qb.push_back(bv[i]); end
    expv = dot_model(qa, qb);
    got4.delete();
    start4 = 1'b1;
    bus4.Output_1_V_V_ap_ack = 1'b0;
    bus4.Input_1_V_V = av[0]; bus4.Input_2_V_V = bv[0];
    bus4.Input_1_V_V_ap_vld = 1'b1; bus4.Input_2_V_V_ap_vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.Input_1_V_V_ap_ack !== 1'b0 || bus4.Input_2_V_V_ap_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL half_valid_ack: cycle %0d ackA=%b ackB=%b required 0", c,
                 bus4.Input_1_V_V_ap_ack, bus4.Input_2_V_V_ap_ack);
      end
      tick();
    end
    run_vec4(qa, qb, 100, -1);
    bus4.Input_1_V_V = 32'd5; bus4.Input_2_V_V = 32'd5;
    bus4.Input_1_V_V_ap_vld = 1'b1; bus4.Input_2_V_V_ap_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.Output_1_V_V_ap_vld !== 1'b1 || bus4.Output_1_V_V !== expv || bus4.Input_1_V_V_ap_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pending_hold: cycle %0d vld=%b data=%h ack=%b required 1 %h 0", c,
                 bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V, bus4.Input_1_V_V_ap_ack, expv);
      end
      tick();
    end
    bus4.Output_1_V_V_ap_ack = 1'b1;
    tick();
    bus4.Output_1_V_V_ap_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.Input_1_V_V_ap_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL next_vector_start: ack=%b required 1 cycle after result accepted", bus4.Input_1_V_V_ap_ack);
    end
    tick();
    checks++;
    if (got4.size() != 1 || got4[0] !== expv) begin
      errors++;
      $display("[TB] FAIL backpressure_result: count=%0d required 1 value %h", got4.size(), expv);
    end
    got4.delete();
    for (int i = 0; i < 3; i++) begin na.push_back(5); nb.push_back(5); end
    run_vec4(na, nb, 100, -1);
    na.push_back(5); nb.push_back(5);
    wait_result4(dot_model(na, nb), "resume_vector");
    tick();
  endtask

  task automatic test_reset_mid();
    ivec_t p9, ones, twos;
    for (int i = 0; i < 2; i++) p9.push_back(9);
    for (int i = 0; i < 4; i++) begin ones.push_back(1); twos.push_back(2); end
    got4.delete();
    start4 = 1'b1;
    bus4.Output_1_V_V_ap_ack = 1'b1;
    run_vec4(p9, p9, 100, -1);
    bus4.Input_1_V_V_ap_vld = 1'b1; bus4.Input_2_V_V_ap_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (idle4 !== 1'b1 || bus4.Input_1_V_V_ap_ack !== 1'b0 || bus4.Output_1_V_V_ap_vld !== 1'b0 || bus4.Output_1_V_V !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_mid: idle=%b ack=%b vld=%b data=%h required 1 0 0 0",
               idle4, bus4.Input_1_V_V_ap_ack, bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    bus4.Input_1_V_V_ap_vld = 1'b0; bus4.Input_2_V_V_ap_vld = 1'b0;
    run_vec4(ones, twos, 100, -1);
    wait_result4(dot_model(ones, twos), "post_reset_sum");
    bus4.Output_1_V_V_ap_ack = 1'b0;
    run_vec4(ones, ones, 100, -1);
    @(negedge clk);
    checks++;
    if (bus4.Output_1_V_V_ap_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_before_reset: vld=%b required 1", bus4.Output_1_V_V_ap_vld);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.Output_1_V_V_ap_vld !== 1'b0 || bus4.Output_1_V_V !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_pending_out: vld=%b data=%h required 0 0", bus4.Output_1_V_V_ap_vld, bus4.Output_1_V_V);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    got4.delete();
    bus4.Output_1_V_V_ap_ack = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (got4.size() != 0) begin
      errors++;
      $display("[TB] FAIL discarded_result: results=%0d required 0", got4.size());
    end
  endtask

  task automatic test_random();
    localparam int NVEC = 6;
    logic [31:0] expq[$];
    int guard = 0;
    got4.delete();
    done4_cnt = 0;
    start4 = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      ivec_t qa, qb;
      for (int i = 0; i < 4; i++) begin
        if (v % 2 == 0) begin
          qa.push_back(int'($urandom));
          qb.push_back(int'($urandom));
        end else begin
          qa.push_back(int'($urandom_range(200)) - 100);
          qb.push_back(int'($urandom_range(200)) - 100);
        end
      end
      expq.push_back(dot_model(qa, qb));
      run_vec4(qa, qb, 70, 50);
    end
    bus4.Output_1_V_V_ap_ack = 1'b1;
    while (got4.size() < NVEC && guard < 100) begin
      tick();
      guard++;
    end
    bus4.Output_1_V_V_ap_ack = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (got4.size() != NVEC || done4_cnt != NVEC) begin
      errors++;
      $display("[TB] FAIL random_count: results=%0d dones=%0d required %0d", got4.size(), done4_cnt, NVEC);
    end
    for (int v = 0; v < NVEC && v < got4.size(); v++) begin
      checks++;
      if (got4[v] !== expq[v]) begin
        errors++;
        $display("[TB] FAIL random_vec%0d: got %h required %h", v, got4[v], expq[v]);
      end
    end
    start4 = 1'b0;
  endtask

  task automatic test_wrap();
    ivec_t qa, qb;
    int j = 0;
    int guard = 0;
    logic [31:0] expv;
    qa.push_back(-3); qb.push_back(4);
    qa.push_back(32'h7FFFFFFF); qb.push_back(2);
    expv = dot_model(qa, qb);
    start2 = 1'b1;
    bus2.Output_1_V_V_ap_ack = 1'b0;
    while (j < 2 && guard < 20) begin
      bus2.Input_1_V_V = qa[j]; bus2.Input_2_V_V = qb[j];
      bus2.Input_1_V_V_ap_vld = 1'b1; bus2.Input_2_V_V_ap_vld = 1'b1;
      @(negedge clk);
      if (bus2.Input_1_V_V_ap_ack === 1'b1) j++;
      tick();
      guard++;
    end
    bus2.Input_1_V_V_ap_vld = 1'b0; bus2.Input_2_V_V_ap_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.Output_1_V_V_ap_vld !== 1'b1 || bus2.Output_1_V_V !== expv || $isunknown(bus2.Output_1_V_V)) begin
      errors++;
      $display("[TB] FAIL wrap_result: vld=%b data=%h required vld=1 data=%h", bus2.Output_1_V_V_ap_vld, bus2.Output_1_V_V, expv);
    end
    bus2.Output_1_V_V_ap_ack = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    ivec_t m1;
    int results = 0;
    int dones = 0;
    int last_cyc = -1;
    logic [31:0] expv;
    m1.push_back(-1);
    expv = dot_model(m1, m1);
    start1 = 1'b1;
    bus1.Output_1_V_V_ap_ack = 1'b1;
    bus1.Input_1_V_V = 32'hFFFFFFFF; bus1.Input_2_V_V = 32'hFFFFFFFF;
    bus1.Input_1_V_V_ap_vld = 1'b1; bus1.Input_2_V_V_ap_vld = 1'b1;
    for (int c = 0; c < 27; c++) begin
      if (c == 24) begin
        bus1.Input_1_V_V_ap_vld = 1'b0; bus1.Input_2_V_V_ap_vld = 1'b0;
      end
      @(negedge clk);
      if (done1 === 1'b1) dones++;
      if (bus1.Output_1_V_V_ap_vld === 1'b1) begin
        results++;
        checks++;
        if (bus1.Output_1_V_V !== expv) begin
          errors++;
          $display("[TB] FAIL stream_value: cycle %0d got %h required %h", c, bus1.Output_1_V_V, expv);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc != 2) begin
            errors++;
            $display("[TB] FAIL stream_period: gap %0d required 2", c - last_cyc);
          end
        end
        last_cyc = c;
      end
      tick();
    end
    checks++;
    if (results < 10 || dones != results) begin
      errors++;
      $display("[TB] FAIL stream_count: results=%0d dones=%0d required >=10 and equal", results, dones);
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
